// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore-style sequencer for the 8-bit accumulator multicycle CPU datapath.
// Ports:
//   clk, rst          clock and asynchronous active-high reset (forces IDLE)
//   IrToCU[3:0]       IR[7:4] opcode nibble
//   DiToCU[4:0]       latched IR[4:0]; only the datapath consumes it (select code 00)
//   CznToCU[2:0]      flags {N,Z,C}; only Z is consulted, by JZ
//   pcInc..memoryWriteEn   register, operand, result, flag and memory strobes
//   accAddressSel     00=DI[4:3], 01=IR[1:0], 10=IR[3:2]
//   PcOrTR, regOrMem, RegBOr0, RegAOr0, aluOpControl   datapath selects
//   halted            high while in HALT
module multicycle_control_unit #(
   parameter logic [1:0] OP_ADD = 2'b00,
   parameter logic [1:0] OP_SUB = 2'b01,
   parameter logic [1:0] OP_AND = 2'b10,
   parameter logic [1:0] OP_NOT = 2'b11
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] IrToCU,
   input  logic [4:0] DiToCU,
   input  logic [2:0] CznToCU,
   output logic       pcInc,
   output logic       pcLoadEn,
   output logic       diLoadEn,
   output logic       irWriteEn,
   output logic       trWriteEn,
   output logic       aRegWriteEn,
   output logic       bRegWriteEn,
   output logic       aluResWriteEn,
   output logic       ldCZN,
   output logic       accumulatorWriteEn,
   output logic       memoryWriteEn,
   output logic [1:0] accAddressSel,
   output logic       PcOrTR,
   output logic       regOrMem,
   output logic       RegBOr0,
   output logic       RegAOr0,
   output logic [1:0] aluOpControl,
   output logic       halted
);
   typedef enum logic [3:0] {
      IDLE, FETCH, DECODE, FETCH2, LD_MEM, ST_RD, PASS, ST_WR,
      JUMP, RR_RDA, RR_RDB, RR_EXE, WB, HALT
   } state_t;
   state_t state_q, state_d;
   logic unused_ok;
   // The register select code is resolved in the datapath; C and N never steer sequencing.
   assign unused_ok = ^{DiToCU, CznToCU[2], CznToCU[0]};
   always_ff @(posedge clk or posedge rst)
      if (rst) state_q <= IDLE;
      else state_q <= state_d;
   always_comb begin
      state_d = state_q;
      pcInc = 1'b0;
      pcLoadEn = 1'b0;
      diLoadEn = 1'b0;
      irWriteEn = 1'b0;
      trWriteEn = 1'b0;
      aRegWriteEn = 1'b0;
      bRegWriteEn = 1'b0;
      aluResWriteEn = 1'b0;
      ldCZN = 1'b0;
      accumulatorWriteEn = 1'b0;
      memoryWriteEn = 1'b0;
      accAddressSel = 2'b00;
      PcOrTR = 1'b0;
      regOrMem = 1'b0;
      RegBOr0 = 1'b0;
      RegAOr0 = 1'b0;
      aluOpControl = OP_ADD;
      halted = 1'b0;
      case (state_q)
         IDLE: state_d = FETCH;
         FETCH: begin
            PcOrTR = 1'b1;
            irWriteEn = 1'b1;
            pcInc = 1'b1;
            state_d = DECODE;
         end
         DECODE: begin
            diLoadEn = 1'b1;
            // 1101 is reserved and falls through to the NOP path.
            state_d = !IrToCU[3] ? FETCH2 :
                      !IrToCU[2] ? RR_RDA :
                      IrToCU == 4'b1100 ? RR_RDB :
                      IrToCU == 4'b1111 ? HALT : FETCH;
         end
         FETCH2: begin
            PcOrTR = 1'b1;
            trWriteEn = 1'b1;
            pcInc = 1'b1;
            state_d = IrToCU[2:1] == 2'b00 ? LD_MEM :
                      IrToCU[2:1] == 2'b01 ? ST_RD : JUMP;
         end
         LD_MEM: begin
            bRegWriteEn = 1'b1;
            state_d = PASS;
         end
         ST_RD: begin
            regOrMem = 1'b1;
            bRegWriteEn = 1'b1;
            state_d = PASS;
         end
         PASS: begin
            RegAOr0 = 1'b1;
            aluResWriteEn = 1'b1;
            state_d = IrToCU[1] ? ST_WR : WB;
         end
         ST_WR: begin
            memoryWriteEn = 1'b1;
            state_d = FETCH;
         end
         JUMP: begin
            // IR[5] separates JMP (always taken) from JZ (taken on Z).
            pcLoadEn = IrToCU[1] | CznToCU[1];
            state_d = FETCH;
         end
         RR_RDA: begin
            accAddressSel = 2'b10;
            aRegWriteEn = 1'b1;
            state_d = RR_RDB;
         end
         RR_RDB: begin
            accAddressSel = 2'b01;
            regOrMem = 1'b1;
            bRegWriteEn = 1'b1;
            state_d = RR_EXE;
         end
         RR_EXE: begin
            // Only MOV (1100) reaches here with IR[6] set.
            aluResWriteEn = 1'b1;
            ldCZN = !IrToCU[2];
            RegAOr0 = IrToCU[2] | (IrToCU[1:0] == 2'b11);
            aluOpControl = IrToCU[2] ? OP_ADD :
                           IrToCU[1:0] == 2'b00 ? OP_ADD :
                           IrToCU[1:0] == 2'b01 ? OP_SUB :
                           IrToCU[1:0] == 2'b10 ? OP_AND : OP_NOT;
            state_d = WB;
         end
         WB: begin
            accumulatorWriteEn = 1'b1;
            accAddressSel = IrToCU[3] ? 2'b10 : 2'b00;
            state_d = FETCH;
         end
         HALT: halted = 1'b1;
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: vector table, random instruction stream and reset corner cases for the control unit.
module tb_multicycle_control_unit;
   logic       clk, rst;
   logic [3:0] IrToCU;
   logic [4:0] DiToCU;
   logic [2:0] CznToCU;
   logic       pcInc, pcLoadEn, diLoadEn, irWriteEn, trWriteEn;
   logic       aRegWriteEn, bRegWriteEn, aluResWriteEn, ldCZN;
   logic       accumulatorWriteEn, memoryWriteEn;
   logic [1:0] accAddressSel, aluOpControl;
   logic       PcOrTR, regOrMem, RegBOr0, RegAOr0, halted;
   logic [19:0] outw;
   multicycle_control_unit dut (
      .clk(clk), .rst(rst), .IrToCU(IrToCU), .DiToCU(DiToCU), .CznToCU(CznToCU),
      .pcInc(pcInc), .pcLoadEn(pcLoadEn), .diLoadEn(diLoadEn), .irWriteEn(irWriteEn),
      .trWriteEn(trWriteEn), .aRegWriteEn(aRegWriteEn), .bRegWriteEn(bRegWriteEn),
      .aluResWriteEn(aluResWriteEn), .ldCZN(ldCZN), .accumulatorWriteEn(accumulatorWriteEn),
      .memoryWriteEn(memoryWriteEn), .accAddressSel(accAddressSel), .PcOrTR(PcOrTR),
      .regOrMem(regOrMem), .RegBOr0(RegBOr0), .RegAOr0(RegAOr0),
      .aluOpControl(aluOpControl), .halted(halted)
   );
   assign outw = {pcInc, pcLoadEn, diLoadEn, irWriteEn, trWriteEn, aRegWriteEn, bRegWriteEn,
                  aluResWriteEn, ldCZN, accumulatorWriteEn, memoryWriteEn, accAddressSel,
                  PcOrTR, regOrMem, RegBOr0, RegAOr0, aluOpControl, halted};
   localparam logic [19:0] PCI = 20'h80000, PCL = 20'h40000, DIL = 20'h20000, IRW = 20'h10000;
   localparam logic [19:0] TRW = 20'h08000, ARW = 20'h04000, BRW = 20'h02000, ALW = 20'h01000;
   localparam logic [19:0] CZN = 20'h00800, ACW = 20'h00400, MEW = 20'h00200;
   localparam logic [19:0] SEL01 = 20'h00080, SEL10 = 20'h00100, PCT = 20'h00040, ROM = 20'h00020;
   localparam logic [19:0] RA0 = 20'h00008, HLT = 20'h00001;
   localparam logic [19:0] W_FETCH = PCI | IRW | PCT;
   typedef struct {
      logic [3:0]  op;
      logic [2:0]  czn;
      int          cyc;
      int          idx;
      logic [19:0] w;
   } vec_t;
   vec_t vt[$];
   logic [19:0] exp_q[$];
   logic [19:0] tr [0:9];
   int n_cyc;
   int checks = 0, errors = 0;
   logic watch = 1'b0, acc_seen = 1'b0;
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(accumulatorWriteEn) if (watch && accumulatorWriteEn) acc_seen = 1'b1;
   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end
   task automatic chk(input string nm, input logic [19:0] got, input logic [19:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, got, exp);
      end
   endtask
   // Per-instruction micro-step list: one expected output word per clock cycle.
   task automatic model(input logic [3:0] op, input logic z);
      exp_q.delete();
      exp_q.push_back(W_FETCH);
      exp_q.push_back(DIL);
      if (!op[3]) begin
         exp_q.push_back(PCT | TRW | PCI);
         case (op[2:1])
            2'b00: begin exp_q.push_back(BRW); exp_q.push_back(ALW | RA0); exp_q.push_back(ACW); end
            2'b01: begin exp_q.push_back(ROM | BRW); exp_q.push_back(ALW | RA0); exp_q.push_back(MEW); end
            2'b10: exp_q.push_back(z ? PCL : 20'h0);
            default: exp_q.push_back(PCL);
         endcase
      end else if (op != 4'hD && op != 4'hE) begin
         if (op != 4'hC) exp_q.push_back(SEL10 | ARW);
         exp_q.push_back(SEL01 | ROM | BRW);
         exp_q.push_back(op == 4'hC ? (ALW | RA0) :
                         (ALW | CZN | (20'(op[1:0]) << 1) | (op[1:0] == 2'b11 ? RA0 : 20'h0)));
         exp_q.push_back(ACW | SEL10);
      end
   endtask
   // Entered one step after an edge with the DUT in FETCH; records words until FETCH recurs.
   task automatic run_instr(input logic [3:0] op, input logic [2:0] f);
      IrToCU = op;
      CznToCU = f;
      n_cyc = 0;
      do begin
         #1;
         tr[n_cyc] = outw;
         n_cyc++;
         @(posedge clk);
         #1;
      end while (n_cyc < 10 && outw !== W_FETCH);
   endtask
   initial begin
      rst = 1'b1;
      IrToCU = 4'h0;
      DiToCU = 5'h0;
      CznToCU = 3'b000;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", outw, 20'h0);
      rst = 1'b0;
      #1;
      chk("idle_outputs", outw, 20'h0);
      @(posedge clk);
      #1;
      chk("first_fetch", outw, W_FETCH);
      vt.push_back('{4'h8, 3'b000, 6, 2, SEL10 | ARW});
      vt.push_back('{4'h8, 3'b000, 6, 3, SEL01 | ROM | BRW});
      vt.push_back('{4'h8, 3'b000, 6, 4, ALW | CZN});
      vt.push_back('{4'h8, 3'b000, 6, 5, ACW | SEL10});
      vt.push_back('{4'h9, 3'b111, 6, 4, ALW | CZN | 20'h2});
      vt.push_back('{4'hA, 3'b010, 6, 4, ALW | CZN | 20'h4});
      vt.push_back('{4'hB, 3'b000, 6, 4, ALW | CZN | 20'h6 | RA0});
      vt.push_back('{4'hC, 3'b111, 5, 3, ALW | RA0});
      vt.push_back('{4'hC, 3'b000, 5, 4, ACW | SEL10});
      vt.push_back('{4'h0, 3'b000, 6, 2, PCT | TRW | PCI});
      vt.push_back('{4'h0, 3'b000, 6, 3, BRW});
      vt.push_back('{4'h1, 3'b010, 6, 5, ACW});
      vt.push_back('{4'h2, 3'b000, 6, 3, ROM | BRW});
      vt.push_back('{4'h2, 3'b000, 6, 4, ALW | RA0});
      vt.push_back('{4'h3, 3'b000, 6, 5, MEW});
      vt.push_back('{4'h4, 3'b010, 4, 3, PCL});
      vt.push_back('{4'h4, 3'b000, 4, 3, 20'h0});
      vt.push_back('{4'h5, 3'b101, 4, 3, 20'h0});
      vt.push_back('{4'h6, 3'b000, 4, 3, PCL});
      vt.push_back('{4'hE, 3'b000, 2, 1, DIL});
      vt.push_back('{4'hD, 3'b000, 2, 1, DIL});
      foreach (vt[i]) begin
         run_instr(vt[i].op, vt[i].czn);
         chk($sformatf("vec%0d_cycles", i), 20'(n_cyc), 20'(vt[i].cyc));
         chk($sformatf("vec%0d_step%0d", i, vt[i].idx), tr[vt[i].idx], vt[i].w);
      end
      for (int k = 0; k < 40; k++) begin
         logic [3:0] op;
         logic [2:0] f;
         op = 4'($urandom_range(0, 14));
         f = 3'($urandom_range(0, 7));
         model(op, f[1]);
         run_instr(op, f);
         chk($sformatf("rnd%0d_op%h_cycles", k, op), 20'(n_cyc), 20'(exp_q.size()));
         for (int j = 0; j < exp_q.size() && j < n_cyc; j++)
            chk($sformatf("rnd%0d_op%h_step%0d", k, op, j), tr[j], exp_q[j]);
      end
      IrToCU = 4'hF;
      CznToCU = 3'b111;
      #1;
      chk("hlt_fetch", outw, W_FETCH);
      @(posedge clk);
      #1;
      chk("hlt_decode", outw, DIL);
      @(posedge clk);
      #1;
      for (int k = 0; k < 100; k++) begin
         chk($sformatf("halt_cycle%0d", k), outw, HLT);
         @(posedge clk);
         #1;
      end
      #2;
      rst = 1'b1;
      #1;
      chk("halt_async_reset", outw, 20'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("halt_reset_idle", outw, 20'h0);
      @(posedge clk);
      #1;
      chk("halt_reset_fetch", outw, W_FETCH);
      IrToCU = 4'h8;
      CznToCU = 3'b000;
      repeat (4) @(posedge clk);
      #1;
      chk("exe_before_reset", outw, ALW | CZN);
      watch = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      chk("exe_async_reset", outw, 20'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("exe_reset_idle", outw, 20'h0);
      @(posedge clk);
      #1;
      chk("exe_reset_fetch", outw, W_FETCH);
      watch = 1'b0;
      chk("exe_reset_no_acc_write", 20'(acc_seen), 20'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
